// File: rtl/vliw_regfile.sv
`default_nettype none
// ============================================================================
// Module      : vliw_regfile
// Description : 4-lane VLIW integer register file (x0-x31 or x0-x15) with
//               8 combinational read ports, same-cycle write bypass, and
//               sticky write-collision / illegal-access error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module vliw_regfile #(
    parameter int XLEN        = 64,
    parameter int E_SUPPORTED = 0,
    parameter int NLANES      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NLANES-1:0]            we3,
    input  logic [NLANES-1:0][4:0]       a1,
    input  logic [NLANES-1:0][4:0]       a2,
    input  logic [NLANES-1:0][4:0]       a3,
    input  logic [NLANES-1:0][XLEN-1:0]  wd3,
    output logic [NLANES-1:0][XLEN-1:0]  rd1,
    output logic [NLANES-1:0][XLEN-1:0]  rd2,
    input  logic                         ClrErr,
    output logic                         WrCollision,
    output logic [7:0]                   CollisionCount,
    output logic                         IllegalAccess
);

    localparam bit c_E_MODE  = (E_SUPPORTED != 0);
    localparam int c_NPORTS  = 2 * NLANES;
    localparam int c_NREGS   = 32;

    logic [XLEN-1:0] r_regs      [c_NREGS];
    logic [XLEN-1:0] w_regs_nxt  [c_NREGS];
    logic [NLANES-1:0] w_wen;
    logic [4:0]      w_raddr     [c_NPORTS];
    logic [XLEN-1:0] w_rdata     [c_NPORTS];
    logic            w_collision;
    logic            w_illegal;
    logic            r_wr_collision;
    logic [7:0]      r_coll_count;
    logic            r_illegal;

    // A lane writes only to a nonzero register that exists in this configuration
    always_comb begin
        for (int l = 0; l < NLANES; l++) begin
            w_wen[l] = we3[l] && (a3[l] != 5'd0) && !(c_E_MODE && a3[l][4]);
        end
    end

    // Ascending lane order lets the highest-numbered lane overwrite the others
    always_comb begin
        w_regs_nxt = r_regs;
        for (int l = 0; l < NLANES; l++) begin
            if (w_wen[l]) begin
                w_regs_nxt[a3[l]] = wd3[l];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regs <= '{default: '0};
        end else begin
            r_regs <= w_regs_nxt;
        end
    end

    always_comb begin
        for (int l = 0; l < NLANES; l++) begin
            w_raddr[l]          = a1[l];
            w_raddr[l + NLANES] = a2[l];
        end
    end

    // Read path: storage, then bypass (highest lane last), then zero masking
    always_comb begin
        for (int p = 0; p < c_NPORTS; p++) begin
            w_rdata[p] = r_regs[w_raddr[p]];
            for (int l = 0; l < NLANES; l++) begin
                if (w_wen[l] && (a3[l] == w_raddr[p])) begin
                    w_rdata[p] = wd3[l];
                end
            end
            if (reset || (w_raddr[p] == 5'd0) || (c_E_MODE && w_raddr[p][4])) begin
                w_rdata[p] = '0;
            end
        end
    end

    for (genvar gl = 0; gl < NLANES; gl++) begin : g_lane_out
        assign rd1[gl] = w_rdata[gl];
        assign rd2[gl] = w_rdata[gl + NLANES];
    end

    always_comb begin
        w_collision = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            for (int j = i + 1; j < NLANES; j++) begin
                if (we3[i] && we3[j] && (a3[i] != 5'd0) && (a3[i] == a3[j])) begin
                    w_collision = 1'b1;
                end
            end
        end
    end

    // Read ports count as active every cycle, so any high read address is illegal
    always_comb begin
        w_illegal = 1'b0;
        if (c_E_MODE) begin
            for (int l = 0; l < NLANES; l++) begin
                if ((we3[l] && a3[l][4]) || a1[l][4] || a2[l][4]) begin
                    w_illegal = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_collision <= 1'b0;
            r_illegal      <= 1'b0;
            r_coll_count   <= 8'd0;
        end else begin
            r_wr_collision <= w_collision | (r_wr_collision & ~ClrErr);
            r_illegal      <= w_illegal   | (r_illegal & ~ClrErr);
            if (w_collision) begin
                if (ClrErr) begin
                    r_coll_count <= 8'd1;
                end else if (r_coll_count != 8'hFF) begin
                    r_coll_count <= r_coll_count + 8'd1;
                end
            end else if (ClrErr) begin
                r_coll_count <= 8'd0;
            end
        end
    end

    assign WrCollision    = r_wr_collision;
    assign CollisionCount = r_coll_count;
    assign IllegalAccess  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_vliw_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_vliw_regfile
// Description : Directed self-checking bench; a full (E=0) and a reduced
//               (E=1) register file share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vliw_regfile;

    logic              clk = 1'b0;
    logic              reset;
    logic              ClrErr;
    logic [3:0]        we3;
    logic [3:0][4:0]   a1, a2, a3;
    logic [3:0][63:0]  wd3;

    logic [3:0][63:0]  m_rd1, m_rd2, e_rd1, e_rd2;
    logic              m_wc, m_ill, e_wc, e_ill;
    logic [7:0]        m_cnt, e_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vliw_regfile #(.XLEN(64), .E_SUPPORTED(0), .NLANES(4)) u_main (
        .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .rd1(m_rd1), .rd2(m_rd2), .ClrErr(ClrErr),
        .WrCollision(m_wc), .CollisionCount(m_cnt), .IllegalAccess(m_ill)
    );

    vliw_regfile #(.XLEN(64), .E_SUPPORTED(1), .NLANES(4)) u_rve (
        .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .rd1(e_rd1), .rd2(e_rd2), .ClrErr(ClrErr),
        .WrCollision(e_wc), .CollisionCount(e_cnt), .IllegalAccess(e_ill)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we3 = '0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; ClrErr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] val(input int r);
        logic [63:0] rr;
        rr = 64'(r);
        return 64'h0123_4567_0000_0000 | (rr << 8) | rr;
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        #2;
        // Writes and a colliding pattern presented during reset
        we3 = 4'hF;
        for (int l = 0; l < 4; l++) begin
            a3[l]  = 5'd3;
            wd3[l] = 64'h77;
        end
        a1[0] = 5'd3;
        #1;
        chk("rst_read_masked", m_rd1[0], 64'h0);
        chk("rst_wc", 64'(m_wc), 64'h0);
        chk("rst_cnt", 64'(m_cnt), 64'h0);
        chk("rst_ill", 64'(e_ill), 64'h0);
        tick();
        chk("rst_wc_after_edge", 64'(m_wc), 64'h0);
        chk("rst_cnt_after_edge", 64'(m_cnt), 64'h0);
        idle();
        reset = 1'b0;
        a1[0] = 5'd3;
        tick();
        chk("rst_write_dropped", m_rd1[0], 64'h0);

        // Basic write with same-cycle bypass
        idle();
        we3[0] = 1'b1; a3[0] = 5'd5; wd3[0] = 64'hDEAD_BEEF;
        a1[2] = 5'd5; a2[1] = 5'd6;
        #1;
        chk("bypass_rd1_l2", m_rd1[2], 64'hDEAD_BEEF);
        chk("unwritten_x6", m_rd2[1], 64'h0);
        tick();
        idle();
        for (int p = 0; p < 4; p++) begin
            a1[p] = 5'd5;
            a2[p] = 5'd5;
        end
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("x5_rd1_l%0d", p), m_rd1[p], 64'hDEAD_BEEF);
            chk($sformatf("x5_rd2_l%0d", p), m_rd2[p], 64'hDEAD_BEEF);
        end

        // Collision lane1 vs lane3 on x7
        idle();
        we3[1] = 1'b1; a3[1] = 5'd7; wd3[1] = 64'h11;
        we3[3] = 1'b1; a3[3] = 5'd7; wd3[3] = 64'h33;
        a1[0] = 5'd7;
        #1;
        chk("coll_bypass", m_rd1[0], 64'h33);
        chk("coll_wc_before_edge", 64'(m_wc), 64'h0);
        tick();
        idle();
        a2[3] = 5'd7;
        #1;
        chk("coll_commit", m_rd2[3], 64'h33);
        chk("coll_wc", 64'(m_wc), 64'h1);
        chk("coll_cnt", 64'(m_cnt), 64'h1);

        // Clear coinciding with a new collision: set wins, count restarts at 1
        we3[0] = 1'b1; a3[0] = 5'd8; wd3[0] = 64'h1;
        we3[2] = 1'b1; a3[2] = 5'd8; wd3[2] = 64'h2;
        ClrErr = 1'b1;
        tick();
        idle();
        a1[3] = 5'd8;
        #1;
        chk("clr_set_wc", 64'(m_wc), 64'h1);
        chk("clr_set_cnt", 64'(m_cnt), 64'h1);
        chk("lane2_beats_lane0", m_rd1[3], 64'h2);

        // Plain clear; reads unaffected
        ClrErr = 1'b1;
        a1[1] = 5'd7;
        #1;
        chk("clr_read_intact", m_rd1[1], 64'h33);
        tick();
        idle();
        chk("clr_wc", 64'(m_wc), 64'h0);
        chk("clr_cnt", 64'(m_cnt), 64'h0);

        // All lanes write x0
        we3 = 4'hF;
        for (int l = 0; l < 4; l++) wd3[l] = 64'hFFFF;
        #1;
        chk("x0_bypass", m_rd1[0], 64'h0);
        tick();
        idle();
        #1;
        chk("x0_read", m_rd1[0], 64'h0);
        chk("x0_no_wc", 64'(m_wc), 64'h0);
        chk("x0_cnt", 64'(m_cnt), 64'h0);

        // Two colliding pairs in one cycle count once
        we3 = 4'hF;
        a3[0] = 5'd11; wd3[0] = 64'hA0;
        a3[1] = 5'd11; wd3[1] = 64'hA1;
        a3[2] = 5'd12; wd3[2] = 64'hB2;
        a3[3] = 5'd12; wd3[3] = 64'hB3;
        tick();
        idle();
        a1[0] = 5'd11; a1[1] = 5'd12;
        #1;
        chk("pairs_x11", m_rd1[0], 64'hA1);
        chk("pairs_x12", m_rd1[1], 64'hB3);
        chk("pairs_cnt", 64'(m_cnt), 64'h1);

        // 300 collision cycles saturate the counter
        ClrErr = 1'b1;
        tick();
        idle();
        we3 = 4'b0011;
        a3[0] = 5'd9; a3[1] = 5'd9;
        for (int i = 0; i < 300; i++) begin
            wd3[0] = 64'(i);
            wd3[1] = 64'(i + 1000);
            tick();
            if (i == 253) chk("sat_cnt_254", 64'(m_cnt), 64'd254);
        end
        chk("sat_cnt_255", 64'(m_cnt), 64'd255);
        chk("sat_wc", 64'(m_wc), 64'h1);
        idle();
        a1[0] = 5'd9;
        #1;
        chk("sat_last_x9", m_rd1[0], 64'd1299);
        ClrErr = 1'b1;
        tick();
        idle();
        chk("sat_clr_cnt", 64'(m_cnt), 64'h0);
        chk("sat_clr_wc", 64'(m_wc), 64'h0);
        chk("sat_clr_ill", 64'(m_ill), 64'h0);

        // Load x1-x31 in both files
        for (int b = 1; b < 32; b += 4) begin
            idle();
            for (int l = 0; l < 4; l++) begin
                if (b + l < 32) begin
                    we3[l] = 1'b1;
                    a3[l]  = 5'(b + l);
                    wd3[l] = val(b + l);
                end
            end
            tick();
        end
        idle();
        for (int r = 1; r < 32; r++) begin
            a1[0] = 5'(r);
            #1;
            chk($sformatf("load_x%0d", r), m_rd1[0], val(r));
        end

        // Reduced register set
        idle();
        ClrErr = 1'b1;
        tick();
        idle();
        chk("rve_ill_cleared", 64'(e_ill), 64'h0);
        we3[0] = 1'b1; a3[0] = 5'd20; wd3[0] = 64'h5;
        tick();
        idle();
        chk("rve_ill_write", 64'(e_ill), 64'h1);
        chk("main_ill_never", 64'(m_ill), 64'h0);
        a1[0] = 5'd20;
        #1;
        chk("rve_x20_zero", e_rd1[0], 64'h0);
        chk("main_x20", m_rd1[0], 64'h5);
        idle();
        for (int r = 1; r < 16; r++) begin
            a2[2] = 5'(r);
            #1;
            chk($sformatf("rve_x%0d_kept", r), e_rd2[2], val(r));
        end
        we3[1] = 1'b1; a3[1] = 5'd20; wd3[1] = 64'h9;
        a1[1] = 5'd20;
        #1;
        chk("rve_no_bypass_hi", e_rd1[1], 64'h0);
        chk("main_bypass_hi", m_rd1[1], 64'h9);
        tick();
        idle();
        ClrErr = 1'b1;
        tick();
        idle();
        chk("rve_ill_clr", 64'(e_ill), 64'h0);
        a2[3] = 5'd17;
        tick();
        idle();
        chk("rve_ill_read", 64'(e_ill), 64'h1);

        // Asynchronous reset between edges
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            a1[p] = 5'(p + 1);
            a2[p] = 5'(p + 28);
        end
        #1;
        chk("pre_reset_x1", m_rd1[0], val(1));
        reset = 1'b1;
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("async_rd1_l%0d", p), m_rd1[p], 64'h0);
            chk($sformatf("async_rd2_l%0d", p), m_rd2[p], 64'h0);
        end
        chk("async_ill", 64'(e_ill), 64'h0);
        tick();
        reset = 1'b0;
        idle();
        we3[0] = 1'b1; a3[0] = 5'd4; wd3[0] = 64'hABC;
        a1[1] = 5'd1;
        #1;
        chk("post_reset_x1", m_rd1[1], 64'h0);
        tick();
        idle();
        a1[0] = 5'd4;
        #1;
        chk("first_write_after_reset", m_rd1[0], 64'hABC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
